// File: rtl/rd_arbiter.sv
// Round-robin arbiter sharing one go/ds read engine; BURST beats per grant, done pulse on completion.
// A ds watchdog drops the grant and raises sticky err/err_id; every output comes straight from a flop.
module rd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int BURST   = 1,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     go,
  input  logic                     ds,
  output logic                     err,
  output logic [$clog2(N_REQ)-1:0] err_id,
  input  logic                     err_clr
);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0]    LAST_BEAT = BW'(BURST - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_MAX - 1);
  localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, GO, WAIT, REL} state_t;

  state_t           state;
  logic [IW-1:0]    last;
  logic [BW-1:0]    beat_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [IW-1:0]    win;
  logic             win_vld;

  // First requester strictly after the previous winner, wrapping; last itself is lowest priority.
  always_comb begin
    int            idx;
    logic [IW-1:0] sel;
    idx     = 0;
    sel     = '0;
    win     = last;
    win_vld = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      sel = IW'(idx);
      if (!win_vld && req[sel]) begin
        win     = sel;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last     <= IW'(N_REQ - 1);
      beat_cnt <= '0;
      tmo_cnt  <= '0;
      gnt      <= '0;
      done     <= '0;
      go       <= 1'b0;
      err      <= 1'b0;
      err_id   <= '0;
    end else begin
      go   <= 1'b0;
      done <= '0;
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= GO;
            gnt      <= ONE << win;
            last     <= win;
            beat_cnt <= '0;
            go       <= 1'b1;
          end
        end
        GO: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A ds arriving on the final watchdog cycle still completes the beat.
          if (ds) begin
            if (beat_cnt == LAST_BEAT) begin
              state <= REL;
              gnt   <= '0;
              done  <= gnt;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              state    <= GO;
              go       <= 1'b1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            err    <= 1'b1;
            err_id <= last;
            gnt    <= '0;
            state  <= IDLE;
          end
        end
        REL: begin
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rd_arbiter.sv
// Bench for rd_arbiter: two instances (BURST=1 and BURST=3, TMO_MAX=10) driven by behavioural read engines.
module tb_rd_arbiter;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] req1 = '0, req3 = '0;
  logic [3:0] gnt1, gnt3, done1, done3;
  logic       go1, go3, ds1, ds3, err1, err3;
  logic       err_clr1 = 1'b0, err_clr3 = 1'b0;
  logic [1:0] err_id1, err_id3;
  logic       eng_ds = 1'b0, eng3_ds = 1'b0, man_ds = 1'b0, eng_mute = 1'b0;
  int         eng_lat = 3, eng_cnt = 0, eng3_cnt = 0, eng3_beat = 0;
  int         errors = 0, checks = 0;
  int         go_cnt1 = 0, go_cnt3 = 0, done_cnt1 = 0, done_cnt3 = 0, ds_cnt3 = 0;
  int         bad_onehot = 0, bad_go = 0, bad_done = 0;
  logic       prev_go1 = 1'b0, prev_go3 = 1'b0;
  logic [3:0] prev_gnt1 = '0, prev_gnt3 = '0;
  int         m_last = 3, m3_last = 3;

  assign ds1 = eng_ds | man_ds;
  assign ds3 = eng3_ds;

  always #5 clk = ~clk;

  rd_arbiter #(.N_REQ(4), .BURST(1), .TMO_W(8), .TMO_MAX(10)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .gnt(gnt1), .done(done1), .go(go1),
    .ds(ds1), .err(err1), .err_id(err_id1), .err_clr(err_clr1));

  rd_arbiter #(.N_REQ(4), .BURST(3), .TMO_W(8), .TMO_MAX(10)) dut3 (
    .clk(clk), .reset_n(reset_n), .req(req3), .gnt(gnt3), .done(done3), .go(go3),
    .ds(ds3), .err(err3), .err_id(err_id3), .err_clr(err_clr3));

  // Engine for dut1: ds eng_lat cycles after go; eng_mute swallows the strobe.
  always @(negedge clk) begin
    eng_ds = 1'b0;
    if (!reset_n) eng_cnt = 0;
    else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0 && !eng_mute) eng_ds = 1'b1;
      end
      if (go1) eng_cnt = eng_lat;
    end
  end

  // Engine for dut3: second read of each grant takes two extra cycles.
  always @(negedge clk) begin
    eng3_ds = 1'b0;
    if (!reset_n) begin
      eng3_cnt  = 0;
      eng3_beat = 0;
    end else begin
      if (gnt3 == 4'b0) eng3_beat = 0;
      if (eng3_cnt > 0) begin
        eng3_cnt--;
        if (eng3_cnt == 0) eng3_ds = 1'b1;
      end
      if (go3) begin
        eng3_cnt = (eng3_beat == 1) ? 5 : 3;
        eng3_beat++;
      end
    end
  end

  always @(negedge clk) begin
    if ($countones(gnt1) > 1 || $countones(gnt3) > 1) bad_onehot++;
    if ((go1 && prev_go1) || (go3 && prev_go3)) bad_go++;
    if ((done1 & ~prev_gnt1) != 4'b0 || (done3 & ~prev_gnt3) != 4'b0) bad_done++;
    go_cnt1   += int'(go1);
    go_cnt3   += int'(go3);
    done_cnt1 += (done1 != 4'b0) ? 1 : 0;
    done_cnt3 += (done3 != 4'b0) ? 1 : 0;
    prev_go1  = go1;
    prev_go3  = go3;
    prev_gnt1 = gnt1;
    prev_gnt3 = gnt3;
  end

  always @(posedge clk) ds_cnt3 += int'(ds3);

  // Reference: winner is the set requester at the smallest rotational distance after the last winner.
  function automatic int model_winner(input logic [3:0] r, input int last);
    int best, bestd, d;
    best = -1; bestd = 99;
    for (int i = 0; i < 4; i++) begin
      d = (i - last - 1 + 8) % 4;
      if (r[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] oh4(input int i);
    return 4'b0001 << i;
  endfunction

  function automatic int first_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_gnt1(output int idx, output int cyc);
    idx = -1; cyc = -1;
    for (int n = 1; n <= 40 && cyc < 0; n++) begin
      @(negedge clk);
      if (gnt1 != 4'b0) begin
        cyc = n;
        idx = first_idx(gnt1);
      end
    end
  endtask

  task automatic wait_release1(input int start, output int hold, output logic [3:0] dn);
    bit fin;
    fin = 1'b0; hold = start; dn = '0;
    for (int n = 0; n < 60 && !fin; n++) begin
      @(negedge clk);
      if (gnt1 == 4'b0) begin
        fin = 1'b1;
        dn  = done1;
      end else hold++;
    end
    if (!fin) hold = -1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (gnt1 !== 4'b0) begin errors++; $display("FAIL reset_gnt got=%b want=0000", gnt1); end
    checks++; if (go1 !== 1'b0) begin errors++; $display("FAIL reset_go got=%b want=0", go1); end
    checks++; if (done1 !== 4'b0) begin errors++; $display("FAIL reset_done got=%b want=0000", done1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err1); end
    checks++; if (err_id1 !== 2'd0) begin errors++; $display("FAIL reset_err_id got=%0d want=0", err_id1); end
    checks++; if (gnt3 !== 4'b0 || err3 !== 1'b0 || err_id3 !== 2'd0) begin
      errors++; $display("FAIL reset_dut3 got=%b/%b/%0d want=0000/0/0", gnt3, err3, err_id3); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (gnt1 !== 4'b0) begin errors++; $display("FAIL idle_no_req got=%b want=0000", gnt1); end
  endtask

  task automatic test_single();
    int idx, cyc, hold, exp, go0;
    logic [3:0] dn;
    go0 = go_cnt1;
    req1 = 4'b0100;
    exp = model_winner(req1, m_last);
    wait_gnt1(idx, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL single_latency got=%0d want=1", cyc); end
    checks++; if (idx != exp) begin errors++; $display("FAIL single_idx got=%0d want=%0d", idx, exp); end
    checks++; if (go1 !== 1'b1) begin errors++; $display("FAIL single_go_with_gnt got=%b want=1", go1); end
    wait_release1(1, hold, dn);
    req1 = 4'b0;
    checks++; if (hold != 4) begin errors++; $display("FAIL single_hold got=%0d want=4", hold); end
    checks++; if (dn !== oh4(exp)) begin errors++; $display("FAIL single_done got=%b want=%b", dn, oh4(exp)); end
    checks++; if (go_cnt1 - go0 != 1) begin errors++; $display("FAIL single_go_count got=%0d want=1", go_cnt1 - go0); end
    @(negedge clk);
    checks++; if (done1 !== 4'b0) begin errors++; $display("FAIL single_done_width got=%b want=0000", done1); end
    m_last = exp;
  endtask

  task automatic test_fairness();
    int idx, cyc, hold, exp, go0, b0;
    logic [3:0] dn;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_last = 3;
    go0 = go_cnt1; b0 = bad_onehot;
    req1 = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      exp = model_winner(req1, m_last);
      wait_gnt1(idx, cyc);
      checks++; if (idx != exp) begin errors++; $display("FAIL fair_order[%0d] got=%0d want=%0d", g, idx, exp); end
      checks++; if (cyc != ((g == 0) ? 1 : 2)) begin
        errors++; $display("FAIL fair_gap[%0d] got=%0d want=%0d", g, cyc, (g == 0) ? 1 : 2); end
      wait_release1(1, hold, dn);
      if (g == 7) req1 = 4'b0;
      checks++; if (dn !== oh4(exp)) begin errors++; $display("FAIL fair_done[%0d] got=%b want=%b", g, dn, oh4(exp)); end
      m_last = exp;
    end
    checks++; if (go_cnt1 - go0 != 8) begin errors++; $display("FAIL fair_go_count got=%0d want=8", go_cnt1 - go0); end
    checks++; if (bad_onehot != b0) begin errors++; $display("FAIL fair_onehot got=%0d want=%0d", bad_onehot, b0); end
  endtask

  task automatic test_burst();
    int cyc, hold, exp, go0, ds0, d0;
    logic [3:0] g, dn;
    bit fin;
    go0 = go_cnt3; ds0 = ds_cnt3; d0 = done_cnt3;
    req3 = 4'b0010;
    exp = model_winner(req3, m3_last);
    cyc = -1; g = '0;
    for (int n = 1; n <= 40 && cyc < 0; n++) begin
      @(negedge clk);
      if (gnt3 != 4'b0) begin cyc = n; g = gnt3; end
    end
    checks++; if (cyc != 1 || g !== oh4(exp)) begin
      errors++; $display("FAIL burst_grant got=%b@%0d want=%b@1", g, cyc, oh4(exp)); end
    fin = 1'b0; hold = 1; dn = '0;
    for (int n = 0; n < 60 && !fin; n++) begin
      @(negedge clk);
      if (gnt3 == 4'b0) begin fin = 1'b1; dn = done3; end
      else hold++;
    end
    req3 = 4'b0;
    m3_last = exp;
    checks++; if (hold != 14) begin errors++; $display("FAIL burst_hold got=%0d want=14", hold); end
    checks++; if (dn !== oh4(exp)) begin errors++; $display("FAIL burst_done got=%b want=%b", dn, oh4(exp)); end
    @(negedge clk);
    checks++; if (go_cnt3 - go0 != 3) begin errors++; $display("FAIL burst_go_count got=%0d want=3", go_cnt3 - go0); end
    checks++; if (ds_cnt3 - ds0 != 3) begin errors++; $display("FAIL burst_ds_count got=%0d want=3", ds_cnt3 - ds0); end
    checks++; if (done_cnt3 - d0 != 1) begin errors++; $display("FAIL burst_done_count got=%0d want=1", done_cnt3 - d0); end
  endtask

  task automatic test_timeout();
    int idx, cyc, hold, exp, d0;
    logic [3:0] dn;
    eng_mute = 1'b1;
    d0 = done_cnt1;
    req1 = 4'b0100;
    exp = model_winner(req1, m_last);
    wait_gnt1(idx, cyc);
    checks++; if (idx != exp) begin errors++; $display("FAIL tmo_idx got=%0d want=%0d", idx, exp); end
    req1 = 4'b0101;
    wait_release1(1, hold, dn);
    checks++; if (hold != 11) begin errors++; $display("FAIL tmo_hold got=%0d want=11", hold); end
    checks++; if (dn !== 4'b0) begin errors++; $display("FAIL tmo_no_done got=%b want=0000", dn); end
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL tmo_err got=%b want=1", err1); end
    checks++; if (err_id1 !== 2'(exp)) begin errors++; $display("FAIL tmo_err_id got=%0d want=%0d", err_id1, exp); end
    m_last = exp;
    exp = model_winner(req1, m_last);
    wait_gnt1(idx, cyc);
    eng_mute = 1'b0;
    req1 = 4'b0;
    checks++; if (cyc != 1 || idx != exp) begin
      errors++; $display("FAIL tmo_next_grant got=%0d@%0d want=%0d@1", idx, cyc, exp); end
    wait_release1(1, hold, dn);
    checks++; if (hold != 4 || dn !== oh4(exp)) begin
      errors++; $display("FAIL tmo_next_done got=%b/%0d want=%b/4", dn, hold, oh4(exp)); end
    m_last = exp;
    @(negedge clk);
    checks++; if (done_cnt1 - d0 != 1) begin errors++; $display("FAIL tmo_done_count got=%0d want=1", done_cnt1 - d0); end
    err_clr1 = 1'b1;
    @(negedge clk);
    err_clr1 = 1'b0;
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL tmo_err_clr got=%b want=0", err1); end
    checks++; if (err_id1 !== 2'd2) begin errors++; $display("FAIL tmo_err_id_hold got=%0d want=2", err_id1); end
  endtask

  task automatic test_simultaneous();
    int idx, cyc, hold, exp, go0;
    logic [3:0] dn;
    // ds lands on the last watchdog cycle
    eng_lat = 10;
    req1 = 4'b1000;
    exp = model_winner(req1, m_last);
    wait_gnt1(idx, cyc);
    req1 = 4'b0;
    wait_release1(1, hold, dn);
    eng_lat = 3;
    checks++; if (hold != 11 || dn !== oh4(exp)) begin
      errors++; $display("FAIL edge_ds_done got=%b/%0d want=%b/11", dn, hold, oh4(exp)); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL edge_ds_no_err got=%b want=0", err1); end
    m_last = exp;
    @(negedge clk);
    // err_clr in the timeout cycle
    eng_mute = 1'b1;
    req1 = 4'b0010;
    exp = model_winner(req1, m_last);
    wait_gnt1(idx, cyc);
    req1 = 4'b0;
    repeat (10) @(negedge clk);
    checks++; if (gnt1 !== oh4(exp)) begin errors++; $display("FAIL clr_pre_gnt got=%b want=%b", gnt1, oh4(exp)); end
    err_clr1 = 1'b1;
    @(negedge clk);
    err_clr1 = 1'b0;
    eng_mute = 1'b0;
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL clr_vs_tmo_err got=%b want=1", err1); end
    checks++; if (err_id1 !== 2'(exp)) begin errors++; $display("FAIL clr_vs_tmo_id got=%0d want=%0d", err_id1, exp); end
    checks++; if (gnt1 !== 4'b0 || done1 !== 4'b0) begin
      errors++; $display("FAIL clr_vs_tmo_out got=%b/%b want=0000/0000", gnt1, done1); end
    m_last = exp;
    // stray ds in IDLE and in GO
    man_ds = 1'b1;
    @(negedge clk);
    man_ds = 1'b0;
    checks++; if (gnt1 !== 4'b0 || go1 !== 1'b0) begin
      errors++; $display("FAIL spur_idle got=%b/%b want=0000/0", gnt1, go1); end
    go0 = go_cnt1;
    req1 = 4'b0001;
    exp = model_winner(req1, m_last);
    wait_gnt1(idx, cyc);
    req1 = 4'b0;
    checks++; if (idx != exp) begin errors++; $display("FAIL spur_idx got=%0d want=%0d", idx, exp); end
    man_ds = 1'b1;
    @(negedge clk);
    man_ds = 1'b0;
    wait_release1(2, hold, dn);
    checks++; if (hold != 4 || dn !== oh4(exp)) begin
      errors++; $display("FAIL spur_go_ignored got=%b/%0d want=%b/4", dn, hold, oh4(exp)); end
    checks++; if (go_cnt1 - go0 != 1) begin errors++; $display("FAIL spur_go_count got=%0d want=1", go_cnt1 - go0); end
    m_last = exp;
    man_ds = 1'b1;
    @(negedge clk);
    man_ds = 1'b0;
  endtask

  task automatic test_reset_mid();
    int idx, cyc, hold, exp;
    logic [3:0] dn;
    eng_mute = 1'b1;
    req1 = 4'b1001;
    exp = model_winner(req1, m_last);
    wait_gnt1(idx, cyc);
    checks++; if (idx != exp) begin errors++; $display("FAIL rst_pre_idx got=%0d want=%0d", idx, exp); end
    repeat (2) @(negedge clk);
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL rst_pre_err got=%b want=1", err1); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (gnt1 !== 4'b0 || go1 !== 1'b0 || done1 !== 4'b0) begin
      errors++; $display("FAIL rst_async_out got=%b/%b/%b want=0000/0/0000", gnt1, go1, done1); end
    checks++; if (err1 !== 1'b0 || err_id1 !== 2'd0) begin
      errors++; $display("FAIL rst_async_err got=%b/%0d want=0/0", err1, err_id1); end
    @(negedge clk);
    reset_n = 1'b1;
    eng_mute = 1'b0;
    m_last = 3;
    exp = model_winner(req1, m_last);
    wait_gnt1(idx, cyc);
    req1 = 4'b0;
    checks++; if (cyc != 1 || idx != exp) begin
      errors++; $display("FAIL rst_first_grant got=%0d@%0d want=%0d@1", idx, cyc, exp); end
    wait_release1(1, hold, dn);
    checks++; if (hold != 4 || dn !== oh4(exp)) begin
      errors++; $display("FAIL rst_first_done got=%b/%0d want=%b/4", dn, hold, oh4(exp)); end
    m_last = exp;
    @(negedge clk);
  endtask

  task automatic test_random();
    int idx, cyc, hold, exp, lat, go0;
    logic [3:0] r, dn;
    for (int t = 0; t < 12; t++) begin
      r   = 4'($urandom_range(15, 1));
      lat = int'($urandom_range(10, 1));
      eng_lat = lat;
      go0 = go_cnt1;
      req1 = r;
      exp = model_winner(r, m_last);
      wait_gnt1(idx, cyc);
      req1 = 4'($urandom);
      checks++; if (cyc != 1 || idx != exp) begin
        errors++; $display("FAIL rand_grant[%0d] req=%b got=%0d@%0d want=%0d@1", t, r, idx, cyc, exp); end
      wait_release1(1, hold, dn);
      req1 = 4'b0;
      checks++; if (hold != 1 + lat) begin
        errors++; $display("FAIL rand_hold[%0d] got=%0d want=%0d", t, hold, 1 + lat); end
      checks++; if (dn !== oh4(exp)) begin
        errors++; $display("FAIL rand_done[%0d] got=%b want=%b", t, dn, oh4(exp)); end
      m_last = exp;
      @(negedge clk);
      checks++; if (go_cnt1 - go0 != 1) begin
        errors++; $display("FAIL rand_go_count[%0d] got=%0d want=1", t, go_cnt1 - go0); end
    end
    eng_lat = 3;
  endtask

  task automatic test_invariants();
    checks++; if (bad_onehot != 0) begin errors++; $display("FAIL inv_onehot got=%0d want=0", bad_onehot); end
    checks++; if (bad_go != 0) begin errors++; $display("FAIL inv_go_consecutive got=%0d want=0", bad_go); end
    checks++; if (bad_done != 0) begin errors++; $display("FAIL inv_done_subset got=%0d want=0", bad_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_burst();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
